// File: rtl/top_uart_rx_buf.sv
// ============================================================================
// Module      : top_uart_rx_buf
// Description : UART receiver with a 2-flop input synchronizer, configurable
//               data width / parity / stop bits, and a first-word
//               fall-through receive FIFO with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_uart_rx_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_i_top_rx,
    input  logic                          rstn_i_top_rx,
    input  logic                          rxd_i,
    input  logic [15:0]                   baud_div_i,
    input  logic                          rx_en_i,
    input  logic                          rd_i,
    input  logic                          err_clr_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o
);

    localparam int   AW         = $clog2(FIFO_DEPTH);
    localparam logic HAS_PARITY = (PARITY_EN != 0);
    localparam logic ODD_BIT    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        PUSH   = 3'd5
    } state_t;

    // Synchronizer and edge detector
    logic sync1, sync2, sync_prev;

    // Receiver datapath
    state_t                state;
    logic [15:0]           timer;
    logic [15:0]           div_q;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  bad_par;
    logic                  bad_frame;
    logic                  busy;

    // FIFO storage
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    // Sticky flags
    logic overrun, frame_err, parity_err;

    // Combinational helpers
    logic [15:0] div_eff;
    logic        start_seen;
    logic        tick;
    logic        frame_good;
    logic        full, empty;
    logic        in_push;
    logic        wr_en, rd_en;
    logic        ovr_set, fe_set, pe_set;
    logic        exp_par;

    // Divisors below 4 would leave no room for a mid-bit sample
    assign div_eff    = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
    assign start_seen = sync_prev & ~sync2;
    assign tick       = (timer == 16'd0);
    assign frame_good = ~bad_par & ~bad_frame;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign in_push    = (state == PUSH);
    // When full, a same-cycle read frees the slot the write lands in
    assign wr_en      = in_push & frame_good & (~full | rd_i);
    assign rd_en      = rd_i & ~empty;
    assign ovr_set    = in_push & frame_good & full & ~rd_i;
    assign fe_set     = in_push & bad_frame;
    assign pe_set     = in_push & bad_par;
    assign exp_par    = (^shift) ^ ODD_BIT;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk_i_top_rx or negedge rstn_i_top_rx) begin
        if (!rstn_i_top_rx) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rxd_i;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Receiver FSM: timer and bit counter reload on every state entry
    always_ff @(posedge clk_i_top_rx or negedge rstn_i_top_rx) begin
        if (!rstn_i_top_rx) begin
            state     <= IDLE;
            timer     <= 16'd0;
            div_q     <= 16'd0;
            bit_cnt   <= 4'd0;
            shift     <= '0;
            bad_par   <= 1'b0;
            bad_frame <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_en_i && start_seen) begin
                        state     <= START;
                        div_q     <= div_eff;
                        timer     <= (div_eff >> 1) - 16'd1;
                        bit_cnt   <= 4'd0;
                        bad_par   <= 1'b0;
                        bad_frame <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_cnt <= 4'd0;
                        if (!sync2) begin
                            state <= DATA;
                            timer <= div_q - 16'd1;
                        end else begin
                            state <= IDLE;
                            timer <= 16'd0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= {sync2, shift[DATA_WIDTH-1:1]};
                        timer <= div_q - 16'd1;
                        if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                            state   <= HAS_PARITY ? PARITY : STOP;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        bad_par <= (sync2 != exp_par);
                        state   <= STOP;
                        timer   <= div_q - 16'd1;
                        bit_cnt <= 4'd0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!sync2) begin
                            bad_frame <= 1'b1;
                        end
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state   <= PUSH;
                            timer   <= 16'd0;
                            bit_cnt <= 4'd0;
                        end else begin
                            timer   <= div_q - 16'd1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                PUSH: begin
                    state   <= IDLE;
                    timer   <= 16'd0;
                    bit_cnt <= 4'd0;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a simultaneous read and write cancel out
    always_ff @(posedge clk_i_top_rx or negedge rstn_i_top_rx) begin
        if (!rstn_i_top_rx) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    // FIFO storage array, written only from a good frame in PUSH
    always_ff @(posedge clk_i_top_rx) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk_i_top_rx or negedge rstn_i_top_rx) begin
        if (!rstn_i_top_rx) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= ovr_set | (overrun    & ~err_clr_i);
            frame_err  <= fe_set  | (frame_err  & ~err_clr_i);
            parity_err <= pe_set  | (parity_err & ~err_clr_i);
        end
    end

    // Head is masked while empty so the output reads zero out of reset
    assign rd_data_o    = empty ? '0 : mem[rd_ptr];
    assign count_o      = count;
    assign full_o       = full;
    assign empty_o      = empty;
    assign busy_o       = busy;
    assign overrun_o    = overrun;
    assign frame_err_o  = frame_err;
    assign parity_err_o = parity_err;

endmodule

`default_nettype wire

// File: tb/tb_top_uart_rx_buf.sv
// ============================================================================
// Module      : tb_top_uart_rx_buf
// Description : Self-checking bench for top_uart_rx_buf. Two instances:
//               0 = 8N1 with a 32-entry FIFO, 1 = 8E2 with a 4-entry FIFO.
//               A frame-level queue model predicts FIFO contents and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_uart_rx_buf;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic        rxd     [2];
    logic        rx_en   [2];
    logic        rd      [2];
    logic        err_clr [2];
    logic [15:0] baud    [2];
    logic [7:0]  rd_data [2];
    logic        full    [2];
    logic        empty   [2];
    logic        busy    [2];
    logic        ovr     [2];
    logic        fe      [2];
    logic        pe      [2];
    logic [5:0]  count0;
    logic [2:0]  count1;

    always #5 clk = ~clk;

    top_uart_rx_buf #(
        .DATA_WIDTH(8), .FIFO_DEPTH(32), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (
        .clk_i_top_rx(clk), .rstn_i_top_rx(rstn), .rxd_i(rxd[0]), .baud_div_i(baud[0]),
        .rx_en_i(rx_en[0]), .rd_i(rd[0]), .err_clr_i(err_clr[0]), .rd_data_o(rd_data[0]),
        .count_o(count0), .full_o(full[0]), .empty_o(empty[0]), .busy_o(busy[0]),
        .overrun_o(ovr[0]), .frame_err_o(fe[0]), .parity_err_o(pe[0])
    );

    top_uart_rx_buf #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut1 (
        .clk_i_top_rx(clk), .rstn_i_top_rx(rstn), .rxd_i(rxd[1]), .baud_div_i(baud[1]),
        .rx_en_i(rx_en[1]), .rd_i(rd[1]), .err_clr_i(err_clr[1]), .rd_data_o(rd_data[1]),
        .count_o(count1), .full_o(full[1]), .empty_o(empty[1]), .busy_o(busy[1]),
        .overrun_o(ovr[1]), .frame_err_o(fe[1]), .parity_err_o(pe[1])
    );

    // ---------------- model state ----------------
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         m_ovr   [2];
    bit         m_fe    [2];
    bit         m_pe    [2];
    bit         settled [2];

    int checks = 0;
    int errors = 0;

    // busy-episode monitor
    int run_len [2];
    int last_len [2];
    int rises [2];
    bit prev_busy [2];
    bit prev_empty [2];
    bit empty_at_fall [2];
    bit empty_before_fall [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 32 : 4;
    endfunction

    function automatic int par_en(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int nstop(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Frame duration in cycles from START entry to return to IDLE
    function automatic int exp_len(input int i, input int b);
        int be;
        be = (b < 4) ? 4 : b;
        return be / 2 + (8 + par_en(i) + nstop(i)) * be + 1;
    endfunction

    function automatic int get_count(input int i);
        return (i == 0) ? int'(count0) : int'(count1);
    endfunction

    function automatic int m_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int m_head(input int i);
        if (m_size(i) == 0) return 0;
        return (i == 0) ? int'(q0[0]) : int'(q1[0]);
    endfunction

    task automatic m_push(input int i, input logic [7:0] d);
        if (i == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic m_pop(input int i);
        logic [7:0] tmp;
        if (i == 0) tmp = q0.pop_front();
        else        tmp = q1.pop_front();
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Per-cycle comparison against the model while an instance is quiescent
    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 2; i++) begin
                chk("full_vs_count", int'(full[i]), int'(get_count(i) == depth_of(i)));
                chk("empty_vs_count", int'(empty[i]), int'(get_count(i) == 0));
                if (settled[i]) begin
                    chk("count", get_count(i), m_size(i));
                    chk("head", int'(rd_data[i]), m_head(i));
                    chk("overrun", int'(ovr[i]), int'(m_ovr[i]));
                    chk("frame_err", int'(fe[i]), int'(m_fe[i]));
                    chk("parity_err", int'(pe[i]), int'(m_pe[i]));
                    chk("busy_idle", int'(busy[i]), 0);
                end
            end
        end
    end

    // Busy-episode length and empty_o behaviour around the end of a frame
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] && !prev_busy[i]) rises[i] <= rises[i] + 1;
            if (busy[i]) begin
                run_len[i] <= run_len[i] + 1;
            end else begin
                if (prev_busy[i]) begin
                    last_len[i]          <= run_len[i];
                    empty_at_fall[i]     <= empty[i];
                    empty_before_fall[i] <= prev_empty[i];
                end
                run_len[i] <= 0;
            end
            prev_busy[i]  <= busy[i];
            prev_empty[i] <= empty[i];
        end
    end

    // All stimulus tasks start and end at posedge + 1
    task automatic drive_bit(input int i, input logic v, input int be);
        rxd[i] = v;
        repeat (be) @(posedge clk);
        #1;
    endtask

    // par_flip: drive the wrong parity bit; push_act: 1 = rd_i, 2 = err_clr_i in PUSH
    task automatic send_frame(input int i, input logic [7:0] d, input int b, input bit bad_stop,
                              input bit par_flip, input int push_act, input bit drop_en);
        int  be, n, r0;
        bit  en0, good, par_bit;
        be       = (b < 4) ? 4 : b;
        en0      = rx_en[i];
        r0       = rises[i];
        settled[i] = 0;
        baud[i]  = 16'(b);
        par_bit  = (^d) ^ par_flip;
        fork
            begin
                drive_bit(i, 1'b0, be);
                baud[i] = 16'($urandom_range(0, 65535));
                if (drop_en) rx_en[i] = 1'b0;
                for (int k = 0; k < 8; k++) drive_bit(i, d[k], be);
                if (par_en(i) != 0) drive_bit(i, par_bit, be);
                for (int s = 0; s < nstop(i); s++) drive_bit(i, ~bad_stop, be);
                rxd[i] = 1'b1;
            end
            begin
                if (push_act != 0) begin
                    n = 0;
                    while (!busy[i] && n < 100) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (!busy[i]) begin
                        chk("push_sync_timeout", 0, 1);
                    end else begin
                        repeat (exp_len(i, b) - 1) @(posedge clk);
                        #1;
                        if (push_act == 1) rd[i] = 1'b1;
                        else               err_clr[i] = 1'b1;
                        @(posedge clk);
                        #1;
                        rd[i]      = 1'b0;
                        err_clr[i] = 1'b0;
                    end
                end
            end
        join
        n = 0;
        while (busy[i] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy[i]) chk("frame_end_timeout", 1, 0);
        repeat (4) @(posedge clk);
        #1;
        baud[i] = 16'(b);
        if (en0) begin
            chk("busy_episodes", rises[i] - r0, 1);
            chk("busy_len", last_len[i], exp_len(i, b));
            good = !bad_stop && !(par_en(i) != 0 && par_flip);
            if (push_act == 2) begin
                m_ovr[i] = 0;
                m_fe[i]  = 0;
                m_pe[i]  = 0;
            end
            if (push_act == 1 && m_size(i) > 0) m_pop(i);
            if (bad_stop) m_fe[i] = 1;
            if (par_en(i) != 0 && par_flip) m_pe[i] = 1;
            if (good) begin
                if (m_size(i) < depth_of(i)) m_push(i, d);
                else                         m_ovr[i] = 1;
            end
        end else begin
            chk("disabled_no_busy", rises[i] - r0, 0);
        end
        settled[i] = 1;
    endtask

    task automatic do_read(input int i);
        bit was_empty;
        settled[i] = 0;
        was_empty  = (m_size(i) == 0);
        chk("rd_data_before_pop", int'(rd_data[i]), m_head(i));
        rd[i] = 1'b1;
        @(posedge clk);
        #1;
        rd[i] = 1'b0;
        if (!was_empty) m_pop(i);
        settled[i] = 1;
    endtask

    task automatic clear_err(input int i);
        settled[i] = 0;
        err_clr[i] = 1'b1;
        @(posedge clk);
        #1;
        err_clr[i] = 1'b0;
        m_ovr[i] = 0;
        m_fe[i]  = 0;
        m_pe[i]  = 0;
        settled[i] = 1;
    endtask

    task automatic check_reset_outputs(input int i);
        chk("rst_count", get_count(i), 0);
        chk("rst_empty", int'(empty[i]), 1);
        chk("rst_full", int'(full[i]), 0);
        chk("rst_busy", int'(busy[i]), 0);
        chk("rst_overrun", int'(ovr[i]), 0);
        chk("rst_frame_err", int'(fe[i]), 0);
        chk("rst_parity_err", int'(pe[i]), 0);
        chk("rst_rd_data", int'(rd_data[i]), 0);
    endtask

    initial begin
        int ri, op, b, r0, guard;
        bit bs, pf;
        int pa;
        for (int i = 0; i < 2; i++) begin
            rxd[i] = 1'b1; rx_en[i] = 1'b1; rd[i] = 1'b0; err_clr[i] = 1'b0;
            baud[i] = 16'd16; settled[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        settled[0] = 1;
        settled[1] = 1;

        // 0xA5 at divisor 16, 8N1
        send_frame(0, 8'hA5, 16, 0, 0, 0, 0);
        chk("a5_busy_len", last_len[0], 153);
        chk("a5_empty_before_fall", int'(empty_before_fall[0]), 1);
        chk("a5_empty_at_fall", int'(empty_at_fall[0]), 0);
        chk("a5_data", int'(rd_data[0]), 8'hA5);
        chk("a5_count", get_count(0), 1);
        do_read(0);
        chk("a5_empty_after_read", int'(empty[0]), 1);
        do_read(0);

        // 4-cycle glitch: rejected in START after 8 cycles
        r0 = rises[0];
        settled[0] = 0;
        rxd[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd[0] = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_busy_pulse", rises[0] - r0, 1);
        chk("glitch_busy_len", last_len[0], 8);
        chk("glitch_count", get_count(0), 0);
        settled[0] = 1;

        // Bad stop bit
        send_frame(0, 8'h3C, 16, 1, 0, 0, 0);
        chk("fe_set", int'(fe[0]), 1);
        chk("fe_count", get_count(0), 0);
        clear_err(0);
        chk("fe_cleared", int'(fe[0]), 0);

        // Even parity on instance 1
        send_frame(1, 8'h07, 16, 0, 1, 0, 0);
        chk("pe_set", int'(pe[1]), 1);
        chk("pe_count", get_count(1), 0);
        send_frame(1, 8'h07, 16, 0, 0, 0, 0);
        chk("par_busy_len", last_len[1], 185);
        chk("par_data", int'(rd_data[1]), 8'h07);
        do_read(1);

        // rx_en dropped mid-frame, then a frame with rx_en low
        send_frame(0, 8'h5A, 16, 0, 0, 0, 1);
        chk("drop_en_stored", int'(rd_data[0]), 8'h5A);
        rx_en[0] = 1'b0;
        send_frame(0, 8'h11, 16, 0, 0, 0, 0);
        rx_en[0] = 1'b1;
        do_read(0);

        // 33 frames into a 32-entry FIFO
        for (int k = 0; k < 33; k++) send_frame(0, 8'(k), 16, 0, 0, 0, 0);
        chk("fill_full", int'(full[0]), 1);
        chk("fill_overrun", int'(ovr[0]), 1);
        chk("fill_count", get_count(0), 32);
        for (int k = 0; k < 32; k++) begin
            chk("fill_order", int'(rd_data[0]), k);
            do_read(0);
        end
        chk("drain_empty", int'(empty[0]), 1);

        // Randomized traffic on both instances
        for (int it = 0; it < 60; it++) begin
            ri = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                b  = int'($urandom_range(2, 10));
                bs = ($urandom_range(0, 7) == 0);
                pf = (ri == 1) && ($urandom_range(0, 5) == 0);
                pa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
                send_frame(ri, 8'($urandom_range(0, 255)), b, bs, pf, pa, 0);
            end else if (op < 9) begin
                do_read(ri);
            end else begin
                clear_err(ri);
            end
        end

        // Full FIFO: write with same-cycle read, then overrun racing a clear
        guard = 0;
        while (m_size(0) < 32 && guard < 40) begin
            send_frame(0, 8'($urandom_range(0, 255)), 4, 0, 0, 0, 0);
            guard++;
        end
        clear_err(0);
        chk("pre_full", int'(full[0]), 1);
        send_frame(0, 8'h77, 16, 0, 0, 1, 0);
        chk("rdwr_full_count", get_count(0), 32);
        chk("rdwr_full_overrun", int'(ovr[0]), 0);
        send_frame(0, 8'h88, 8, 0, 0, 2, 0);
        chk("set_beats_clear", int'(ovr[0]), 1);

        // Reset in the middle of a frame
        settled[0] = 0;
        settled[1] = 0;
        baud[0] = 16'd16;
        rxd[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("busy_before_reset", int'(busy[0]), 1);
        rstn = 1'b0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rxd[0] = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_ovr[i] = 0; m_fe[i] = 0; m_pe[i] = 0;
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        r0 = rises[0];
        repeat (40) @(posedge clk);
        #1;
        chk("post_reset_no_frame", rises[0] - r0, 0);
        chk("post_reset_count", get_count(0), 0);
        settled[0] = 1;
        settled[1] = 1;
        send_frame(0, 8'hC3, 8, 0, 0, 0, 0);
        chk("post_reset_rx", int'(rd_data[0]), 8'hC3);
        repeat (5) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_uart_rx_buf.md
TOP_UART_RX_BUF -- requirements
Module: top_uart_rx_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 32, receive buffer entries; power of two, 4..256.
REQ-003 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-006 clk_i_top_rx  in  1  clock; all logic rising-edge.
REQ-007 rstn_i_top_rx  in  1  reset, asynchronous, active-low.
REQ-008 rxd_i  in  1  asynchronous serial input; idle high.
REQ-009 baud_div_i  in  16  clock cycles per bit; values below 4 are treated as 4.
REQ-010 rx_en_i  in  1  high enables detection of new start bits.
REQ-011 rd_i  in  1  pop request for the FIFO head.
REQ-012 err_clr_i  in  1  clears all sticky error flags.
REQ-013 rd_data_o  out  DATA_WIDTH  FIFO head (first-word fall-through); valid while empty_o=0.
REQ-014 count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 full_o / empty_o  out  1 each  FIFO full / FIFO empty.
REQ-016 busy_o  out  1  high while the receiver FSM is outside IDLE.
REQ-017 overrun_o / frame_err_o / parity_err_o  out  1 each  sticky error flags.

Function
REQ-018 rxd_i SHALL pass through a 2-flop synchronizer; all receiver decisions use the synchronized value.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP, PUSH; the bit timer and bit counter reload on every state entry.
REQ-020 IDLE -> START on a synchronized high-to-low transition while rx_en_i=1.
REQ-021 START: sample after baud_div_i/2 cycles (integer division); low -> DATA, high -> IDLE (glitch rejected, no flags).
REQ-022 DATA: sample every baud_div_i cycles, LSB first, DATA_WIDTH samples; then PARITY if PARITY_EN=1, else STOP.
REQ-023 PARITY: one sample after baud_div_i cycles; mismatch against the even/odd rule over the data bits marks the frame bad-parity.
REQ-024 STOP: STOP_BITS samples spaced baud_div_i cycles apart; any low sample marks the frame bad-frame.
REQ-025 After the last stop sample the FSM SHALL enter PUSH for exactly one cycle, then IDLE.
REQ-026 PUSH with a good frame and full_o=0 (or rd_i=1 in the same cycle): write the byte to the FIFO.
REQ-027 PUSH with a good frame, full_o=1 and rd_i=0: discard the byte; set overrun_o.
REQ-028 A bad-parity or bad-frame frame SHALL never be written; set parity_err_o and/or frame_err_o in PUSH.
REQ-029 Latency: empty_o SHALL fall on the cycle after PUSH (2 cycles after the final stop sample) when the FIFO was empty.
REQ-030 rd_i with empty_o=1 SHALL be ignored; count_o unchanged, no pointer movement.
REQ-031 A simultaneous write and read SHALL leave count_o unchanged, including when the FIFO is full.
REQ-032 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full_o = (count_o==FIFO_DEPTH), empty_o = (count_o==0).
REQ-033 Deasserting rx_en_i mid-frame SHALL let the current frame complete; only new start detection is blocked.
REQ-034 If err_clr_i and a flag-set event coincide in one cycle, set SHALL win.
REQ-035 baud_div_i SHALL be sampled at START entry and held constant for the remainder of the frame.

Reset
REQ-036 While rstn_i_top_rx=0: FSM in IDLE, pointers and count_o=0, empty_o=1, full_o=0, busy_o=0, all error flags 0, rd_data_o=0, synchronizer flops=1.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no write and no flag; after release, a receive requires a fresh start bit.

Verification
REQ-038 baud_div_i=16, 8N1, send 0xA5 -> empty_o falls 2 cycles after the stop sample, rd_data_o=0xA5, count_o=1; rd_i pulse -> empty_o=1.
REQ-039 Send 33 frames 0x00..0x20 with no reads, FIFO_DEPTH=32 -> full_o=1, overrun_o=1, count_o=32; 32 reads return 0x00..0x1F in order.
REQ-040 4-cycle low glitch on rxd_i at baud_div_i=16 -> busy_o pulses, no write, no flags, count_o=0.
REQ-041 Frame 0x3C with stop bit driven low -> frame_err_o=1, count_o unchanged; err_clr_i pulse -> frame_err_o=0.
REQ-042 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err_o=1, no write; repeat with parity bit 1 -> 0x07 stored.
REQ-043 FIFO full with PUSH and rd_i in the same cycle -> new byte stored, count_o stays 32, overrun_o stays 0; assert reset mid-frame -> all outputs at reset values.
